// File: rtl/mux_scan_n_if.sv
// rtl/mux_scan_n_if.sv - channel, control and result bundle for mux_scan_n
// en_mask is present only when MUX_SCAN_SKIP_EN is defined.
interface mux_scan_n_if #(
  parameter int N_CH = 16,
  parameter int W    = 8,
  parameter int SW   = ($clog2(N_CH) < 1) ? 1 : $clog2(N_CH)
);
  logic [N_CH*W-1:0] din;
  logic [SW-1:0]     sel;
  logic              mode;
  logic              hold;
`ifdef MUX_SCAN_SKIP_EN
  logic [N_CH-1:0]   en_mask;
`endif
  logic [W-1:0]      dout;
  logic [SW-1:0]     ch_out;
  logic              out_valid;
  logic              ch_adv;
  logic              err;

`ifdef MUX_SCAN_SKIP_EN
  modport master (output din, sel, mode, hold, en_mask,
                  input  dout, ch_out, out_valid, ch_adv, err);
  modport slave  (input  din, sel, mode, hold, en_mask,
                  output dout, ch_out, out_valid, ch_adv, err);
`else
  modport master (output din, sel, mode, hold,
                  input  dout, ch_out, out_valid, ch_adv, err);
  modport slave  (input  din, sel, mode, hold,
                  output dout, ch_out, out_valid, ch_adv, err);
`endif
endinterface

// File: rtl/mux_scan_n.sv
// rtl/mux_scan_n.sv - registered N-channel mux with manual select and dwell-timed auto-scan
// MUX_SCAN_SKIP_EN adds en_mask so the scan skips disabled channels.
module mux_scan_n #(
  parameter int N_CH  = 16,
  parameter int W     = 8,
  parameter int DWELL = 4
) (
  input logic         clk,
  input logic         rst,
  mux_scan_n_if.slave bus
);
  localparam int SW = ($clog2(N_CH) < 1) ? 1 : $clog2(N_CH);
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SW:0]   NCH_EXT    = (SW+1)'(N_CH);
  localparam logic [SW-1:0] LAST_IDX   = SW'(N_CH - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

  logic [W-1:0]  ch_data [N_CH];
  logic          sel_ok;
  logic          any_en;
  logic [SW-1:0] idx_next;

  logic          mode_q;
  logic [SW-1:0] idx_q, idx_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [W-1:0]  dout_q, dout_d;
  logic [SW-1:0] ch_q, ch_d;
  logic          err_q, err_d;
  logic          adv_q, adv_d;
  logic          valid_q;

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      ch_data[k] = bus.din[k*W +: W];
    end
  end

  assign sel_ok = ({1'b0, bus.sel} < NCH_EXT);

`ifdef MUX_SCAN_SKIP_EN
  int cand;

  // Walk downward so the nearest enabled channel above idx_q is the last one written.
  always_comb begin
    any_en   = |bus.en_mask;
    idx_next = idx_q;
    cand     = 0;
    for (int i = N_CH; i >= 1; i--) begin
      cand = int'(idx_q) + i;
      if (cand >= N_CH) begin
        cand = cand - N_CH;
      end
      if (bus.en_mask[cand[SW-1:0]]) begin
        idx_next = cand[SW-1:0];
      end
    end
  end
`else
  assign any_en   = 1'b1;
  assign idx_next = (idx_q == LAST_IDX) ? '0 : idx_q + SW'(1);
`endif

  always_comb begin
    idx_d   = idx_q;
    dwell_d = dwell_q;
    adv_d   = 1'b0;
    if (bus.mode && !mode_q) begin
      idx_d   = sel_ok ? bus.sel : '0;
      dwell_d = '0;
    end else if (bus.mode) begin
      if (!bus.hold) begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (any_en) begin
            idx_d = idx_next;
            adv_d = 1'b1;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
    end else begin
      dwell_d = '0;
    end

    // Scan mode shows the index as it stands after this edge, so ch_adv lines up with ch_out.
    if (bus.mode) begin
      ch_d   = idx_d;
      err_d  = !any_en;
      dout_d = any_en ? ch_data[idx_d] : '0;
    end else begin
      ch_d   = bus.sel;
      err_d  = !sel_ok;
      dout_d = sel_ok ? ch_data[bus.sel] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= 1'b0;
      idx_q   <= '0;
      dwell_q <= '0;
      dout_q  <= '0;
      ch_q    <= '0;
      err_q   <= 1'b0;
      adv_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      mode_q  <= bus.mode;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      dout_q  <= dout_d;
      ch_q    <= ch_d;
      err_q   <= err_d;
      adv_q   <= adv_d;
      valid_q <= 1'b1;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.ch_out    = ch_q;
  assign bus.err       = err_q;
  assign bus.ch_adv    = adv_q;
  assign bus.out_valid = valid_q;
endmodule
